// File: rtl/bcd_serial_adder_pkg.sv
// bcd_serial_adder_pkg: shared FSM states, BCD limit and seven-segment patterns.
package bcd_serial_adder_pkg;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   localparam logic [3:0] BCD_MAX   = 4'd9;
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd_serial_adder_seg.sv
// bcd_to_seg: BCD digit to seven-segment pattern; non-decimal codes are blank.
module bcd_to_seg
   import bcd_serial_adder_pkg::*;
#(
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic [3:0] i_bcd,
   output logic [6:0] o_seg
);
   logic [6:0] w_pat;
   always_comb begin
      case (i_bcd)
         4'd0:    w_pat = SEG_0;
         4'd1:    w_pat = SEG_1;
         4'd2:    w_pat = SEG_2;
         4'd3:    w_pat = SEG_3;
         4'd4:    w_pat = SEG_4;
         4'd5:    w_pat = SEG_5;
         4'd6:    w_pat = SEG_6;
         4'd7:    w_pat = SEG_7;
         4'd8:    w_pat = SEG_8;
         4'd9:    w_pat = SEG_9;
         default: w_pat = SEG_BLANK;
      endcase
   end
   assign o_seg = SEG_ACTIVE_LOW ? w_pat : ~w_pat;
endmodule

// File: rtl/bcd_serial_adder.sv
// bcd_serial_adder: digit-serial packed-BCD adder with seven-segment result display.
module bcd_serial_adder
   import bcd_serial_adder_pkg::*;
#(
   parameter int DIGITS         = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1
) (
   input  logic                    CLOCK_50,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic [4*DIGITS-1:0]     a,
   input  logic [4*DIGITS-1:0]     b,
   input  logic                    cin,
   output logic [4*DIGITS-1:0]     sum,
   output logic                    cout,
   output logic                    busy,
   output logic                    done,
   output logic                    err,
   output logic [7*(DIGITS+1)-1:0] hex
);
   localparam int W  = 4*DIGITS;
   localparam int IW = $clog2(DIGITS+1);
   state_t         r_state, w_next;
   logic [W-1:0]   r_a, r_b, r_shadow, r_sum, w_next_shadow;
   logic [IW-1:0]  r_idx;
   logic           r_c, r_cout, r_err, r_valid;
   logic           w_bad, w_last, w_gt, w_cap;
   logic [4:0]     w_t;
   logic [3:0]     w_dsum;
   always_comb begin
      w_bad = 1'b0;
      for (int i = 0; i < DIGITS; i++)
         w_bad = w_bad | (a[4*i+:4] > BCD_MAX) | (b[4*i+:4] > BCD_MAX);
   end
   // One digit adder; operands shift down so digit i is always in bits [3:0].
   assign w_t           = 5'(r_a[3:0]) + 5'(r_b[3:0]) + 5'(r_c);
   assign w_gt          = w_t > 5'(BCD_MAX);
   assign w_dsum        = w_gt ? 4'(w_t - 5'd10) : w_t[3:0];
   assign w_next_shadow = W'({w_dsum, r_shadow} >> 4);
   assign w_last        = r_idx == IW'(DIGITS-1);
   assign w_cap         = (r_state == IDLE) && start;
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    w_next = start ? (w_bad ? DONE : ADD) : IDLE;
         ADD:     w_next = w_last ? DONE : ADD;
         default: w_next = IDLE;
      endcase
   end
   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end
   always_ff @(posedge CLOCK_50) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_c      <= 1'b0;
         r_idx    <= '0;
         r_shadow <= '0;
         r_sum    <= '0;
         r_cout   <= 1'b0;
         r_err    <= 1'b0;
         r_valid  <= 1'b0;
      end else if (w_cap) begin
         r_a      <= a;
         r_b      <= b;
         r_c      <= cin;
         r_idx    <= '0;
         r_shadow <= '0;
         if (w_bad) begin
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_err   <= 1'b1;
            r_valid <= 1'b0;
         end
      end else if (r_state == ADD) begin
         r_a      <= r_a >> 4;
         r_b      <= r_b >> 4;
         r_c      <= w_gt;
         r_idx    <= r_idx + IW'(1);
         r_shadow <= w_next_shadow;
         if (w_last) begin
            r_sum   <= w_next_shadow;
            r_cout  <= w_gt;
            r_err   <= 1'b0;
            r_valid <= 1'b1;
         end
      end
   end
   assign sum  = r_sum;
   assign cout = r_cout;
   assign err  = r_err;
   assign busy = r_state == ADD;
   assign done = r_state == DONE;
   // Blank code 0xF is fed after reset and on error so every field goes dark.
   for (genvar g = 0; g <= DIGITS; g++) begin : g_seg
      logic [3:0] w_dig;
      if (g < DIGITS) begin : g_d
         assign w_dig = r_valid ? r_sum[4*g+:4] : 4'hF;
      end else begin : g_c
         assign w_dig = r_valid ? {3'b000, r_cout} : 4'hF;
      end
      bcd_to_seg #(.SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)) u_seg (
         .i_bcd (w_dig),
         .o_seg (hex[7*g+:7])
      );
   end
endmodule

// File: tb/tb_bcd_serial_adder.sv
// tb_bcd_serial_adder: directed checks of the 2-digit and 4-digit BCD serial adder.
module tb_bcd_serial_adder;
   logic        clk = 1'b0;
   logic        rst_n, start, cin, start4, cin4;
   logic [7:0]  a, b, sum;
   logic        cout, busy, done, err;
   logic [20:0] hex;
   logic [15:0] a4, b4, sum4;
   logic        cout4, busy4, done4, err4;
   logic [34:0] hex4;
   int          n_checks = 0;
   int          n_fail = 0;

   always #5 clk = ~clk;

   bcd_serial_adder #(.DIGITS(2), .SEG_ACTIVE_LOW(1'b1)) dut (
      .CLOCK_50(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
      .sum(sum), .cout(cout), .busy(busy), .done(done), .err(err), .hex(hex));

   bcd_serial_adder #(.DIGITS(4), .SEG_ACTIVE_LOW(1'b1)) dut4 (
      .CLOCK_50(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .sum(sum4), .cout(cout4), .busy(busy4), .done(done4), .err(err4), .hex(hex4));

   // Starts an operation from a negedge; lat = negedges until done (99 = timeout).
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic, output int lat);
      a = ia; b = ib; cin = ic; start = 1'b1; lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin lat = i; break; end
      end
   endtask

   task automatic run_op4(input logic [15:0] ia, input logic [15:0] ib, input logic ic, output int lat);
      a4 = ia; b4 = ib; cin4 = ic; start4 = 1'b1; lat = 99;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         start4 = 1'b0;
         if (done4) begin lat = i; break; end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b1; start4 = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0;
      a4 = '0; b4 = '0; cin4 = 1'b0;
      repeat (3) @(negedge clk);
      start = 1'b0; start4 = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      n_checks++; if (sum !== 8'h00) begin n_fail++; $display("FAIL reset_sum got %h want 00", sum); end
      n_checks++; if ({cout, busy, done, err} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags got %b want 0000", {cout, busy, done, err}); end
      n_checks++; if (hex !== 21'h1FFFFF) begin n_fail++; $display("FAIL reset_hex got %h want 1fffff", hex); end
      n_checks++; if (sum4 !== 16'h0000 || hex4 !== {35{1'b1}}) begin n_fail++; $display("FAIL reset_dut4 got sum %h hex %h", sum4, hex4); end
   endtask

   task automatic test_add_basic();
      int lat;
      logic [7:0] mid_busy;
      a = 8'h45; b = 8'h38; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      mid_busy = {7'd0, busy};
      lat = 99;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (done) begin lat = i; break; end
      end
      n_checks++; if (mid_busy !== 8'd1) begin n_fail++; $display("FAIL basic_busy got %0d want 1", mid_busy); end
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL basic_latency got %0d want 3", lat); end
      n_checks++; if (sum !== 8'h83 || cout !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL basic_sum got %h/%b/%b want 83/0/0", sum, cout, err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done got %b want 0", busy); end
      n_checks++; if (hex !== {7'b1000000, 7'b0000000, 7'b0110000}) begin n_fail++; $display("FAIL basic_hex got %b want 100000000000000110000", hex); end
      repeat (3) @(negedge clk);
      n_checks++; if (done !== 1'b0 || sum !== 8'h83) begin n_fail++; $display("FAIL basic_hold got done %b sum %h want 0 83", done, sum); end
   endtask

   task automatic test_add_carry();
      int lat;
      run_op(8'h99, 8'h99, 1'b1, lat);
      n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL carry_latency got %0d want 3", lat); end
      n_checks++; if (sum !== 8'h99 || cout !== 1'b1) begin n_fail++; $display("FAIL carry_sum got %h/%b want 99/1", sum, cout); end
      n_checks++; if (hex !== {7'b1111001, 7'b0010000, 7'b0010000}) begin n_fail++; $display("FAIL carry_hex got %b", hex); end
      @(negedge clk);
   endtask

   task automatic test_err();
      int lat;
      run_op(8'h1A, 8'h05, 1'b0, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL err_latency got %0d want 1", lat); end
      n_checks++; if (err !== 1'b1 || sum !== 8'h00 || cout !== 1'b0) begin n_fail++; $display("FAIL err_flags got err %b sum %h cout %b want 1 00 0", err, sum, cout); end
      n_checks++; if (hex !== 21'h1FFFFF) begin n_fail++; $display("FAIL err_hex got %h want 1fffff", hex); end
      @(negedge clk);
      run_op(8'h12, 8'h34, 1'b0, lat);
      n_checks++; if (lat !== 3 || err !== 1'b0 || sum !== 8'h46) begin n_fail++; $display("FAIL err_clear got lat %0d err %b sum %h want 3 0 46", lat, err, sum); end
      n_checks++; if (hex !== {7'b1000000, 7'b0011001, 7'b0000010}) begin n_fail++; $display("FAIL err_clear_hex got %b", hex); end
      @(negedge clk);
   endtask

   task automatic test_start_ignored();
      int lat = 99;
      int n_done = 0;
      a = 8'h27; b = 8'h15; cin = 1'b0; start = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (n_done > 0) start = 1'b0;
         if (i == 1) begin a = 8'h11; b = 8'h11; end
         if (done) begin n_done++; if (lat == 99) lat = i; end
      end
      start = 1'b0;
      n_checks++; if (n_done !== 1 || lat !== 3) begin n_fail++; $display("FAIL restart_pulses got %0d at %0d want 1 at 3", n_done, lat); end
      n_checks++; if (sum !== 8'h42 || cout !== 1'b0) begin n_fail++; $display("FAIL restart_sum got %h/%b want 42/0", sum, cout); end
   endtask

   task automatic test_reset_abort();
      int lat;
      int n_done = 0;
      a = 8'h45; b = 8'h38; cin = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      if (done) n_done++;
      @(negedge clk);
      if (done) n_done++;
      rst_n = 1'b0;
      @(negedge clk);
      if (done) n_done++;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (done) n_done++;
      end
      n_checks++; if (n_done !== 0) begin n_fail++; $display("FAIL abort_done got %0d pulses want 0", n_done); end
      n_checks++; if (sum !== 8'h00 || busy !== 1'b0 || cout !== 1'b0) begin n_fail++; $display("FAIL abort_state got sum %h busy %b cout %b want 00 0 0", sum, busy, cout); end
      n_checks++; if (hex !== 21'h1FFFFF) begin n_fail++; $display("FAIL abort_hex got %h want 1fffff", hex); end
      run_op(8'h45, 8'h38, 1'b0, lat);
      n_checks++; if (lat !== 3 || sum !== 8'h83) begin n_fail++; $display("FAIL abort_recover got lat %0d sum %h want 3 83", lat, sum); end
      @(negedge clk);
   endtask

   task automatic test_four_digit();
      int lat;
      run_op4(16'h9999, 16'h0001, 1'b0, lat);
      n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL d4_latency got %0d want 5", lat); end
      n_checks++; if (sum4 !== 16'h0000 || cout4 !== 1'b1 || err4 !== 1'b0) begin n_fail++; $display("FAIL d4_sum got %h/%b/%b want 0000/1/0", sum4, cout4, err4); end
      n_checks++; if (hex4 !== {7'b1111001, {4{7'b1000000}}}) begin n_fail++; $display("FAIL d4_hex got %b", hex4); end
      @(negedge clk);
      run_op4(16'h1234, 16'h5678, 1'b1, lat);
      n_checks++; if (lat !== 5 || sum4 !== 16'h6913 || cout4 !== 1'b0) begin n_fail++; $display("FAIL d4_mixed got lat %0d sum %h cout %b want 5 6913 0", lat, sum4, cout4); end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_add_basic();
      test_add_carry();
      test_err();
      test_start_ignored();
      test_reset_abort();
      test_four_digit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 The block SHALL have parameter DIGITS, default 2, meaning the number of BCD digits per operand (range 1..8).
REQ-002 The block SHALL have parameter SEG_ACTIVE_LOW, default 1, meaning 1 drives segment patterns active-low and 0 inverts them.
REQ-003 The block SHALL have port CLOCK_50  in  1  system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-005 The block SHALL have port start  in  1  request to add; sampled only in IDLE.
REQ-006 The block SHALL have port a  in  4*DIGITS  operand A as packed BCD, with digit 0 in bits [3:0].
REQ-007 The block SHALL have port b  in  4*DIGITS  operand B as packed BCD.
REQ-008 The block SHALL have port cin  in  1  carry into digit 0.
REQ-009 The block SHALL have port sum  out  4*DIGITS  registered BCD result.
REQ-010 The block SHALL have port cout  out  1  registered decimal carry out of the top digit.
REQ-011 The block SHALL have port busy  out  1  high while an operation is in progress.
REQ-012 The block SHALL have port done  out  1  one-cycle pulse when the result is valid.
REQ-013 The block SHALL have port err  out  1  registered flag; high when a captured operand nibble is greater than 9.
REQ-014 The block SHALL have port hex  out  7*(DIGITS+1)  seven-segment patterns; field i (i < DIGITS) shows sum digit i, and field DIGITS shows cout.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, ADD and DONE.
REQ-016 In IDLE with start=1, the block SHALL capture a, b and cin into internal registers, clear the digit index, and assert busy from the next cycle.
REQ-017 On capture, if any nibble of a or b is greater than 9, the next state SHALL be DONE with err=1, sum=0 and cout=0; otherwise the next state SHALL be ADD with err=0.
REQ-018 ADD SHALL process one digit per cycle, starting at digit 0: t = a_i + b_i + c (5-bit); if t > 9 then sum_i = t - 10 and c = 1, else sum_i = t and c = 0.
REQ-019 After digit DIGITS-1 is processed, cout SHALL take the final c and the state SHALL move to DONE.
REQ-020 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-021 With start sampled at edge k, done SHALL be high in cycle k+DIGITS+1 for a valid add, and in cycle k+1 for err.
REQ-022 start SHALL be ignored in ADD and DONE; no capture and no restart occur.
REQ-023 sum, cout, err and hex SHALL hold their values from the last completed operation until the next DONE.
REQ-024 sum digits SHALL be built in a shadow register, and the visible sum and hex SHALL update only in the DONE cycle.
REQ-025 In active-low form, digit patterns SHALL be: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000; any other value SHALL be blank (1111111).
REQ-026 The hex field for cout SHALL show digit 0 or 1.
REQ-027 When err=1, every hex field SHALL be blank.
REQ-028 start and rst_n low in the same cycle SHALL resolve to reset.

Reset
REQ-029 With rst_n=0 at a clock edge, the block SHALL enter IDLE and clear busy, done, err, cout, sum and the internal registers to 0.
REQ-030 The hex fields SHALL be blank after reset.
REQ-031 Reset during ADD SHALL abort the operation without a done pulse, and outputs SHALL take their reset values.

Structure
REQ-032 A shared package SHALL hold the state enum, the ten segment-pattern constants with the blank pattern, and the constant BCD_MAX=9.
REQ-033 A combinational sub-module bcd_to_seg (4-bit in, 7-bit out, honours SEG_ACTIVE_LOW) SHALL be instantiated DIGITS+1 times.
REQ-034 The digit-serial adder SHALL reuse a single 4-bit digit-add datapath, not one per digit.

Verification
REQ-035 DIGITS=2; a=0x45, b=0x38, cin=0, start pulse -> done 3 cycles later; sum=0x83, cout=0, hex0=0000000, hex1=0110000, hex2=1000000.
REQ-036 a=0x99, b=0x99, cin=1 -> sum=0x99, cout=1, hex2=1111001.
REQ-037 a=0x1A, b=0x05 -> done 1 cycle after start; err=1, sum=0, all hex blank; a following valid add clears err.
REQ-038 start re-asserted every cycle during ADD -> exactly one done pulse, and the result matches the first capture.
REQ-039 rst_n low during the second ADD cycle -> no done pulse, sum=0, busy=0, hex blank; the next add completes normally.
REQ-040 DIGITS=4; a=0x9999, b=0x0001 -> sum=0x0000 and cout=1 after 5 cycles.
